// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 master: valid/ready command in, SETUP/ACCESS cycles out, one-cycle response strobe.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [AWIDTH-1:0]   paddr_q;
  logic [DWIDTH-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DWIDTH-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q;
`endif

  // Bridge FSM; every APB and response output is a flop updated here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          // Slave response is only meaningful on the PREADY cycle.
          if (PREADY) begin
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt_q == TO_MAX) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
